display_bcd_driver: RTL and testbench
=====================================

DISPLAY_BCD_DRIVER -- requirements
Module: display_bcd_driver

Interface
REQ-001 SHALL have parameter WIDTH, default 32, bit width of the binary input value (range 4..32).
REQ-002 SHALL have parameter DIGITS, default 8, number of 7-segment digits driven (range 1..10).
REQ-003 SHALL have parameter BLANK_LEADING, default 1, meaning 1 enables leading-zero blanking.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes occur on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port load  input  1  conversion request, sampled only in IDLE.
REQ-007 SHALL have port value  input  WIDTH  binary value, captured on the accepted load edge.
REQ-008 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse when seg is updated.
REQ-010 SHALL have port overflow  output  1  result did not fit in DIGITS digits; held until the next update.
REQ-011 SHALL have port seg  output  7*DIGITS  active-low segments; digit k at bits [7k+6:7k], digit 0 least significant.

Function
REQ-012 SHALL implement FSM IDLE -> SHIFT -> LATCH -> IDLE with registered outputs.
REQ-013 SHALL, in IDLE with load=1 at edge E0, capture value, clear the internal BCD register, set busy=1 and enter SHIFT.
REQ-014 SHALL perform WIDTH shift-add-3 (double-dabble) iterations at edges E1..E_WIDTH, one bit per edge, MSB first.
REQ-015 SHALL size the internal BCD register at NI = (WIDTH*3)/10 + 1 digits, independent of DIGITS.
REQ-016 SHALL, in LATCH at edge E_WIDTH+1, update seg, overflow and done=1, clear busy and return to IDLE; done falls at the next edge.
REQ-017 SHALL ignore load while busy=1; captured value and timing are unaffected.
REQ-018 SHALL accept a load asserted in the cycle in which done=1, since the FSM is already in IDLE.
REQ-019 SHALL encode digits 0-9 active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; blank=1111111.
REQ-020 SHALL set overflow=1 when any BCD digit at index >= DIGITS is nonzero; the low DIGITS digits are then shown unblanked.
REQ-021 SHALL, when BLANK_LEADING=1 and overflow=0, blank every digit above the most significant nonzero digit; digit 0 is always shown.
REQ-022 SHALL hold seg and overflow constant between updates.

Reset
REQ-023 SHALL, while reset=0, force state IDLE, busy=0, done=0, overflow=0 and seg all ones (all digits blank).
REQ-024 SHALL abort an in-progress conversion on reset without any seg update; the first load after reset release starts a fresh conversion.

Configuration
REQ-025 SHALL use macro DISPLAY_BCD_SIGNED_EN.
REQ-026 SHALL, with DISPLAY_BCD_SIGNED_EN defined, treat value as two's complement, convert its magnitude, and show minus (0111111) on the digit immediately above the most significant shown digit.
REQ-027 SHALL, with DISPLAY_BCD_SIGNED_EN defined and BLANK_LEADING=0, place the minus on digit DIGITS-1 and count that digit as unavailable for magnitude.
REQ-028 SHALL, with DISPLAY_BCD_SIGNED_EN defined, set overflow=1 when a negative magnitude needs all DIGITS digits, leaving no room for the sign.
REQ-029 SHALL, without DISPLAY_BCD_SIGNED_EN, treat value as unsigned and never drive the minus pattern.
REQ-030 SHALL keep the port list and latency identical in both builds.

Verification
REQ-031 SHALL cover: WIDTH=32, DIGITS=8, load value 0 -> done exactly 33 cycles after the load edge, seg[6:0]=1000000, other digits 1111111, overflow=0.
REQ-032 SHALL cover: value 12345678 -> digits 7..0 show 1,2,3,4,5,6,7,8, no blanking, overflow=0.
REQ-033 SHALL cover: value 100000000 -> overflow=1 and all eight digits show 0 unblanked; a following value 5 -> overflow=0, only digit 0 shown (5).
REQ-034 SHALL cover: load value 7, then load value 9 asserted 10 cycles later -> second load ignored, seg shows 7; a load in the done cycle is accepted.
REQ-035 SHALL cover: reset pulled low 5 cycles after load -> seg all blank, busy=0, done never pulses; a new load of 42 completes normally.
REQ-036 SHALL cover, with DISPLAY_BCD_SIGNED_EN defined: value 32'hFFFFFFD6 (-42) -> digit 2 shows minus, digits 1..0 show 4,2; value -12345678 -> overflow=1.

Source files
------------

// File: rtl/display_bcd_driver.sv
// rtl/display_bcd_driver.sv - binary to 7-segment BCD display driver (optional signed build: DISPLAY_BCD_SIGNED_EN)
module display_bcd_driver #(
    parameter int WIDTH         = 32,
    parameter int DIGITS        = 8,
    parameter int BLANK_LEADING = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [WIDTH-1:0]      value,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int NI = (WIDTH * 3) / 10 + 1;
    localparam int ND = (NI > DIGITS) ? NI : DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   sreg;
    logic [WIDTH-1:0]   mag;
    logic               neg_q;
    logic [NI*4-1:0]    bcd;
    logic [NI*4-1:0]    bcd_adj;
    logic [NI*4-1:0]    bcd_step;
    logic [ND*4-1:0]    bcd_ext;
    logic [7*DIGITS-1:0] seg_next;
    logic               ovf_next;
    int                 hi_idx;
    int                 limit;

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        case (d)
            4'd0:    seg_encode = 7'b1000000;
            4'd1:    seg_encode = 7'b1111001;
            4'd2:    seg_encode = 7'b0100100;
            4'd3:    seg_encode = 7'b0110000;
            4'd4:    seg_encode = 7'b0011001;
            4'd5:    seg_encode = 7'b0010010;
            4'd6:    seg_encode = 7'b0000010;
            4'd7:    seg_encode = 7'b1111000;
            4'd8:    seg_encode = 7'b0000000;
            4'd9:    seg_encode = 7'b0010000;
            default: seg_encode = SEG_BLANK;
        endcase
    endfunction

`ifdef DISPLAY_BCD_SIGNED_EN
    // Convert the magnitude; the sign is remembered separately for the minus digit.
    assign mag = value[WIDTH-1] ? ((~value) + WIDTH'(1)) : value;

    // Sign flag captured alongside the value on an accepted load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            neg_q <= 1'b0;
        end else if (state == IDLE && load) begin
            neg_q <= value[WIDTH-1];
        end
    end
`else
    assign mag   = value;
    assign neg_q = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: one cycle per input bit, then a single latch cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load) state_next = SHIFT;
            SHIFT:   if (cnt == CW'(WIDTH - 1)) state_next = LATCH;
            LATCH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One double-dabble step: add 3 to every digit >= 5, then shift in the next bit.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < NI; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
        bcd_step = (bcd_adj << 1) | {{(NI*4-1){1'b0}}, sreg[WIDTH-1]};
    end

    // Conversion datapath: capture on load, shift MSB first while in SHIFT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            sreg <= '0;
            bcd  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        sreg <= mag;
                        bcd  <= '0;
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    bcd  <= bcd_step;
                    sreg <= sreg << 1;
                    cnt  <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Display formatting: overflow detection, leading-zero blanking and minus placement.
    always_comb begin
        bcd_ext = '0;
        bcd_ext[NI*4-1:0] = bcd;
        hi_idx = 0;
        for (int i = 0; i < ND; i++) begin
            if (bcd_ext[i*4 +: 4] != 4'd0) hi_idx = i;
        end
        // A negative result reserves one digit for the sign.
        limit    = neg_q ? (DIGITS - 1) : DIGITS;
        ovf_next = (hi_idx >= limit);
        seg_next = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (ovf_next) begin
                seg_next[k*7 +: 7] = seg_encode(bcd_ext[k*4 +: 4]);
            end else if (neg_q && BLANK_LEADING == 0 && k == DIGITS - 1) begin
                seg_next[k*7 +: 7] = SEG_MINUS;
            end else if (neg_q && BLANK_LEADING != 0 && k == hi_idx + 1) begin
                seg_next[k*7 +: 7] = SEG_MINUS;
            end else if (BLANK_LEADING != 0 && k > hi_idx) begin
                seg_next[k*7 +: 7] = SEG_BLANK;
            end else begin
                seg_next[k*7 +: 7] = seg_encode(bcd_ext[k*4 +: 4]);
            end
        end
    end

    // Registered outputs: busy spans SHIFT..LATCH, seg/overflow only change with the done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            seg      <= '1;
        end else begin
            done <= 1'b0;
            if (state == IDLE && load) begin
                busy <= 1'b1;
            end
            if (state == LATCH) begin
                busy     <= 1'b0;
                done     <= 1'b1;
                seg      <= seg_next;
                overflow <= ovf_next;
            end
        end
    end

endmodule

// File: tb/tb_display_bcd_driver.sv
// tb/tb_display_bcd_driver.sv - scoreboard bench for display_bcd_driver (WIDTH=32, DIGITS=8)
module tb_display_bcd_driver;

    logic        clk;
    logic        reset;
    logic        load;
    logic [31:0] value;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [55:0] seg;

    typedef struct {
        logic [55:0] seg;
        logic        ov;
    } exp_t;

    exp_t q[$];
    int   total;
    int   bad;
    int   cyc;
    int   load_cyc;
    int   done_cnt;
    bit   wchk;

    display_bcd_driver #(.WIDTH(32), .DIGITS(8), .BLANK_LEADING(1)) dut (
        .clk(clk), .reset(reset), .load(load), .value(value),
        .busy(busy), .done(done), .overflow(overflow), .seg(seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] v);
        exp_t         e;
        longint       m;
        bit           neg;
        int           n;
        int           lim;
        logic [3:0]   d [10];
        logic [6:0]   tbl [10];
        tbl[0] = 7'b1000000; tbl[1] = 7'b1111001; tbl[2] = 7'b0100100; tbl[3] = 7'b0110000;
        tbl[4] = 7'b0011001; tbl[5] = 7'b0010010; tbl[6] = 7'b0000010; tbl[7] = 7'b1111000;
        tbl[8] = 7'b0000000; tbl[9] = 7'b0010000;
        m   = longint'(v);
        neg = 1'b0;
`ifdef DISPLAY_BCD_SIGNED_EN
        if (v[31]) begin
            neg = 1'b1;
            m   = 64'sd4294967296 - longint'(v);
        end
`endif
        n = 1;
        for (int i = 0; i < 10; i++) begin
            d[i] = 4'(m % 10);
            m    = m / 10;
            if (d[i] != 0) n = i + 1;
        end
        lim  = neg ? 7 : 8;
        e.ov = (n > lim);
        for (int k = 0; k < 8; k++) begin
            if (e.ov || k < n)        e.seg[k*7 +: 7] = tbl[d[k]];
            else if (neg && k == n)   e.seg[k*7 +: 7] = 7'b0111111;
            else                      e.seg[k*7 +: 7] = 7'b1111111;
        end
        return e;
    endfunction

    // Scoreboard: every done pulse consumes one expectation; done must drop next cycle.
    always @(negedge clk) begin
        exp_t e;
        if (wchk) begin
            chk("done_width", done, 0);
            wchk = 1'b0;
        end
        if (done) begin
            done_cnt++;
            wchk = 1'b1;
            if (q.size() == 0) begin
                chk("unexpected_done", done, 0);
            end else begin
                e = q.pop_front();
                chk("seg", seg, e.seg);
                chk("ovf", overflow, e.ov);
            end
        end
    end

    task automatic do_load(input logic [31:0] v);
        value = v;
        load  = 1'b1;
        @(posedge clk);
        #1;
        load_cyc = cyc;
        load     = 1'b0;
        q.push_back(model(v));
    endtask

    task automatic wait_done();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        chk("done_seen", got, 1);
        if (got) chk("latency", cyc - load_cyc, 33);
    endtask

    task automatic run(input logic [31:0] v);
        do_load(v);
        wait_done();
    endtask

    initial begin
        int dc;
        total = 0; bad = 0; cyc = 0; done_cnt = 0; wchk = 1'b0;
        reset = 1'b0; load = 1'b0; value = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_seg", seg, {56{1'b1}});
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", overflow, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        run(32'd0);
        run(32'd12345678);
        run(32'd100000000);
        run(32'd5);
        run(32'd10);
        run(32'd99999999);
        run(32'hFFFFFFFF);
`ifdef DISPLAY_BCD_SIGNED_EN
        run(32'hFFFFFFD6);
        run(-32'sd12345678);
        run(-32'sd1234567);
`endif

        do_load(32'd7);
        repeat (9) @(posedge clk);
        #1;
        value = 32'd9;
        load  = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        chk("busy_ign", busy, 1);
        wait_done();
        do_load(32'd9);
        wait_done();

        do_load(32'd1234);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_seg", seg, {56{1'b1}});
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        q.delete();
        dc = done_cnt;
        reset = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt, dc);
        chk("abort_seg_hold", seg, {56{1'b1}});
        run(32'd42);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_busy", busy, 0);
        chk("queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
